// File: rtl/line_merge_buffer_if.sv
// Bundles the system write port, the cache fetch port and the cache writeback port of line_merge_buffer.
// The buffer uses the slave modport; the system/cache side uses the master modport.
interface line_merge_buffer_if #(
    parameter int LINE_WIDTH   = 64,
    parameter int WORD_WIDTH   = 32,
    parameter int OFFSET_WIDTH = 3,
    parameter int ADDR_WIDTH   = 32
);
    logic                             sys_wr_valid;
    logic                             sys_wr_ready;
    logic [ADDR_WIDTH-1:0]            sys_addr;
    logic [WORD_WIDTH-1:0]            sys_wdata;
    logic [WORD_WIDTH/8-1:0]          sys_bval;
    logic                             flush;
    logic                             busy;
    logic                             rd_req;
    logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] rd_addr;
    logic                             rd_ack;
    logic [LINE_WIDTH-1:0]            rd_data;
    logic                             wr_req;
    logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] wr_addr;
    logic [LINE_WIDTH-1:0]            wr_data;
    logic                             wr_ack;

    modport slave (
        input  sys_wr_valid, sys_addr, sys_wdata, sys_bval, flush, rd_ack, rd_data, wr_ack,
        output sys_wr_ready, busy, rd_req, rd_addr, wr_req, wr_addr, wr_data
    );

    modport master (
        output sys_wr_valid, sys_addr, sys_wdata, sys_bval, flush, rd_ack, rd_data, wr_ack,
        input  sys_wr_ready, busy, rd_req, rd_addr, wr_req, wr_addr, wr_data
    );
endinterface

// File: rtl/line_merge_buffer.sv
// Single-line write-combining buffer: fetch on first touch, merge byte-enabled writes, write back on change/flush.
// Optional idle-timeout writeback is enabled by defining LINE_MERGE_TIMEOUT_EN.
module line_merge_buffer #(
    parameter int LINE_WIDTH     = 64,
    parameter int WORD_WIDTH     = 32,
    parameter int OFFSET_WIDTH   = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    line_merge_buffer_if.slave    bus
);
    localparam int BYTES_PER_WORD = WORD_WIDTH / 8;
    localparam int BYTE_OFF_W     = $clog2(BYTES_PER_WORD);
    localparam int LINE_ADDR_W    = ADDR_WIDTH - OFFSET_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    // Overlay the enabled bytes of one word onto the line; the word slot comes from the byte offset.
    function automatic logic [LINE_WIDTH-1:0] merge_line(
        input logic [LINE_WIDTH-1:0]     line,
        input logic [OFFSET_WIDTH-1:0]   offset,
        input logic [WORD_WIDTH-1:0]     wdata,
        input logic [BYTES_PER_WORD-1:0] bval
    );
        logic [LINE_WIDTH-1:0] res;
        int                    base;
        res  = line;
        base = int'(offset >> BYTE_OFF_W) * WORD_WIDTH;
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
            if (bval[b]) begin
                res[base + 8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

    state_t                    state_r, state_s;
    logic [LINE_WIDTH-1:0]     line_r, line_s;
    logic [LINE_ADDR_W-1:0]    line_addr_r, line_addr_s;
    logic [OFFSET_WIDTH-1:0]   pend_off_r, pend_off_s;
    logic [WORD_WIDTH-1:0]     pend_data_r, pend_data_s;
    logic [BYTES_PER_WORD-1:0] pend_bval_r, pend_bval_s;
    logic                      ready_en_r;
    logic                      ready_s;
    logic                      same_line_s;

`ifdef LINE_MERGE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_cnt_r, idle_cnt_s;
`endif

    assign same_line_s = (bus.sys_addr[ADDR_WIDTH-1:OFFSET_WIDTH] == line_addr_r);

    // Next-state, merge datapath and write-acceptance decode.
    always_comb begin
        state_s     = state_r;
        line_s      = line_r;
        line_addr_s = line_addr_r;
        pend_off_s  = pend_off_r;
        pend_data_s = pend_data_r;
        pend_bval_s = pend_bval_r;
        ready_s     = 1'b0;
`ifdef LINE_MERGE_TIMEOUT_EN
        idle_cnt_s  = idle_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (ready_en_r && !bus.flush) begin
                    ready_s = 1'b1;
                    if (bus.sys_wr_valid) begin
                        line_addr_s = bus.sys_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
                        pend_off_s  = bus.sys_addr[OFFSET_WIDTH-1:0];
                        pend_data_s = bus.sys_wdata;
                        pend_bval_s = bus.sys_bval;
                        state_s     = ST_FETCH;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    ready_s = 1'b0;
                end
            end
            ST_FETCH: begin
                if (bus.rd_ack) begin
                    line_s  = merge_line(bus.rd_data, pend_off_r, pend_data_r, pend_bval_r);
                    state_s = ST_HOLD;
`ifdef LINE_MERGE_TIMEOUT_EN
                    idle_cnt_s = {TO_W{1'b0}};
`endif
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_HOLD: begin
                // Flush wins over a simultaneous write, which then waits for the next IDLE.
                if (bus.flush) begin
                    state_s = ST_WRITE;
                end else if (bus.sys_wr_valid) begin
                    if (same_line_s) begin
                        ready_s = 1'b1;
                        line_s  = merge_line(line_r, bus.sys_addr[OFFSET_WIDTH-1:0],
                                             bus.sys_wdata, bus.sys_bval);
`ifdef LINE_MERGE_TIMEOUT_EN
                        idle_cnt_s = {TO_W{1'b0}};
`endif
                    end else begin
                        state_s = ST_WRITE;
                    end
                end else begin
`ifdef LINE_MERGE_TIMEOUT_EN
                    if (idle_cnt_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_s = ST_WRITE;
                    end else begin
                        idle_cnt_s = idle_cnt_r + TO_W'(1);
                    end
`else
                    state_s = ST_HOLD;
`endif
                end
            end
            ST_WRITE: begin
                if (bus.wr_ack) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, line buffer and pending-write registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            line_r      <= {LINE_WIDTH{1'b0}};
            line_addr_r <= {LINE_ADDR_W{1'b0}};
            pend_off_r  <= {OFFSET_WIDTH{1'b0}};
            pend_data_r <= {WORD_WIDTH{1'b0}};
            pend_bval_r <= {BYTES_PER_WORD{1'b0}};
        end else begin
            state_r     <= state_s;
            line_r      <= line_s;
            line_addr_r <= line_addr_s;
            pend_off_r  <= pend_off_s;
            pend_data_r <= pend_data_s;
            pend_bval_r <= pend_bval_s;
        end
    end

    // Holds sys_wr_ready low while reset is asserted and until the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

`ifdef LINE_MERGE_TIMEOUT_EN
    // Idle-cycle counter for automatic writeback from HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_r <= {TO_W{1'b0}};
        end else begin
            idle_cnt_r <= idle_cnt_s;
        end
    end
`endif

    assign bus.sys_wr_ready = ready_s;
    assign bus.busy         = (state_r != ST_IDLE);
    assign bus.rd_req       = (state_r == ST_FETCH);
    assign bus.rd_addr      = line_addr_r;
    assign bus.wr_req       = (state_r == ST_WRITE);
    assign bus.wr_addr      = line_addr_r;
    assign bus.wr_data      = line_r;
endmodule

// File: tb/tb_line_merge_buffer.sv
// Directed self-checking bench for line_merge_buffer; timeout expectations follow LINE_MERGE_TIMEOUT_EN.
module tb_line_merge_buffer;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    line_merge_buffer_if #(
        .LINE_WIDTH(64), .WORD_WIDTH(32), .OFFSET_WIDTH(3), .ADDR_WIDTH(32)
    ) bus ();

    line_merge_buffer #(
        .LINE_WIDTH(64), .WORD_WIDTH(32), .OFFSET_WIDTH(3), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] bval);
        bus.sys_wr_valid = 1'b1;
        bus.sys_addr     = addr;
        bus.sys_wdata    = data;
        bus.sys_bval     = bval;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n            = 1'b0;
        bus.sys_wr_valid = 1'b0;
        bus.sys_addr     = 32'h0;
        bus.sys_wdata    = 32'h0;
        bus.sys_bval     = 4'h0;
        bus.flush        = 1'b0;
        bus.rd_ack       = 1'b0;
        bus.rd_data      = 64'h0;
        bus.wr_ack       = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_ready", {63'd0, bus.sys_wr_ready}, 64'd0);
        check_val("rst_busy",  {63'd0, bus.busy},         64'd0);
        check_val("rst_rdreq", {63'd0, bus.rd_req},       64'd0);
        check_val("rst_wrreq", {63'd0, bus.wr_req},       64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_ready", {63'd0, bus.sys_wr_ready}, 64'd1);

        // Flush and stray rd_ack in IDLE are ignored
        bus.flush  = 1'b1;
        bus.rd_ack = 1'b1;
        #1 check_val("idle_flush_ready", {63'd0, bus.sys_wr_ready}, 64'd0);
        @(negedge clk);
        bus.flush  = 1'b0;
        bus.rd_ack = 1'b0;
        check_val("idle_flush_busy", {63'd0, bus.busy}, 64'd0);

        // First write fetches line 0x20 and merges word 0
        drive_wr(32'h100, 32'hAABBCCDD, 4'hF);
        #1 check_val("w0_ready", {63'd0, bus.sys_wr_ready}, 64'd1);
        @(negedge clk);
        bus.sys_wr_valid = 1'b0;
        check_val("fetch_rdreq",  {63'd0, bus.rd_req}, 64'd1);
        check_val("fetch_rdaddr", {35'd0, bus.rd_addr}, 64'h20);
        check_val("fetch_busy",   {63'd0, bus.busy},   64'd1);
        bus.rd_ack  = 1'b1;
        bus.rd_data = 64'h11223344_55667788;
        @(negedge clk);
        bus.rd_ack  = 1'b0;
        bus.rd_data = 64'hDEADBEEF_DEADBEEF;
        check_val("hold_rdreq", {63'd0, bus.rd_req}, 64'd0);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check_val("flush_wrreq",  {63'd0, bus.wr_req},  64'd1);
        check_val("flush_wraddr", {35'd0, bus.wr_addr}, 64'h20);
        check_val("flush_wrdata", bus.wr_data, 64'h11223344_AABBCCDD);
        @(negedge clk);
        check_val("wr_stable_data", bus.wr_data, 64'h11223344_AABBCCDD);
        check_val("wr_stable_req",  {63'd0, bus.wr_req}, 64'd1);
        bus.wr_ack = 1'b1;
        @(negedge clk);
        bus.wr_ack = 1'b0;
        check_val("wb_done_busy", {63'd0, bus.busy}, 64'd0);

        // Zero byte-enable write refetches line 0x20 unchanged
        drive_wr(32'h100, 32'h99999999, 4'h0);
        #1 check_val("bval0_ready", {63'd0, bus.sys_wr_ready}, 64'd1);
        @(negedge clk);
        bus.sys_wr_valid = 1'b0;
        bus.rd_ack  = 1'b1;
        bus.rd_data = 64'h11223344_AABBCCDD;
        @(negedge clk);
        bus.rd_ack = 1'b0;

        // Back-to-back same-line merges, then a line change
        drive_wr(32'h104, 32'h000000EE, 4'h1);
        #1 check_val("hold_w1_ready", {63'd0, bus.sys_wr_ready}, 64'd1);
        @(negedge clk);
        drive_wr(32'h104, 32'hFF000000, 4'h8);
        #1 check_val("hold_w2_ready", {63'd0, bus.sys_wr_ready}, 64'd1);
        @(negedge clk);
        drive_wr(32'h108, 32'h12345678, 4'h3);
        #1 check_val("line_change_stall", {63'd0, bus.sys_wr_ready}, 64'd0);
        @(negedge clk);
        check_val("lc_wrreq",  {63'd0, bus.wr_req},  64'd1);
        check_val("lc_wraddr", {35'd0, bus.wr_addr}, 64'h20);
        check_val("lc_wrdata", bus.wr_data, 64'hFF2233EE_AABBCCDD);
        #1 check_val("lc_write_ready", {63'd0, bus.sys_wr_ready}, 64'd0);
        bus.wr_ack = 1'b1;
        @(negedge clk);
        bus.wr_ack = 1'b0;
        #1 check_val("lc_idle_accept", {63'd0, bus.sys_wr_ready}, 64'd1);
        @(negedge clk);
        bus.sys_wr_valid = 1'b0;
        check_val("lc_rdreq",  {63'd0, bus.rd_req},  64'd1);
        check_val("lc_rdaddr", {35'd0, bus.rd_addr}, 64'h21);
        bus.rd_ack  = 1'b1;
        bus.rd_data = 64'h0;
        @(negedge clk);
        bus.rd_ack = 1'b0;

        // Flush beats a simultaneous same-line write
        bus.flush = 1'b1;
        drive_wr(32'h10C, 32'hCAFEBABE, 4'hF);
        #1 check_val("flush_prio_ready", {63'd0, bus.sys_wr_ready}, 64'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        check_val("fp_wraddr", {35'd0, bus.wr_addr}, 64'h21);
        check_val("fp_wrdata", bus.wr_data, 64'h00000000_00005678);
        bus.wr_ack = 1'b1;
        #1 check_val("fp_write_ready", {63'd0, bus.sys_wr_ready}, 64'd0);
        @(negedge clk);
        bus.wr_ack = 1'b0;
        #1 check_val("fp_idle_accept", {63'd0, bus.sys_wr_ready}, 64'd1);
        @(negedge clk);
        bus.sys_wr_valid = 1'b0;
        check_val("fp_rdaddr", {35'd0, bus.rd_addr}, 64'h21);
        bus.rd_ack  = 1'b1;
        bus.rd_data = 64'h00000000_00005678;
        @(negedge clk);
        bus.rd_ack = 1'b0;
        bus.flush  = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check_val("fp_merged", bus.wr_data, 64'hCAFEBABE_00005678);

        // Reset while a writeback is outstanding
        rst_n = 1'b0;
        #1;
        check_val("rstw_wrreq", {63'd0, bus.wr_req},       64'd0);
        check_val("rstw_busy",  {63'd0, bus.busy},         64'd0);
        check_val("rstw_ready", {63'd0, bus.sys_wr_ready}, 64'd0);
        check_val("rstw_data",  bus.wr_data,               64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rstw_idle_ready", {63'd0, bus.sys_wr_ready}, 64'd1);
        check_val("rstw_idle_wrreq", {63'd0, bus.wr_req},       64'd0);

        // Idle timeout: 15 idle, a write, then 16 idle cycles in HOLD
        drive_wr(32'h200, 32'h00000001, 4'hF);
        @(negedge clk);
        bus.sys_wr_valid = 1'b0;
        bus.rd_ack  = 1'b1;
        bus.rd_data = 64'h0;
        @(negedge clk);
        bus.rd_ack = 1'b0;
        repeat (15) @(negedge clk);
        check_val("to_run15", {63'd0, bus.wr_req}, 64'd0);
        drive_wr(32'h204, 32'h00000002, 4'hF);
        #1 check_val("to_write_ready", {63'd0, bus.sys_wr_ready}, 64'd1);
        @(negedge clk);
        bus.sys_wr_valid = 1'b0;
        repeat (15) @(negedge clk);
        check_val("to_second15", {63'd0, bus.wr_req}, 64'd0);
        @(negedge clk);
`ifdef LINE_MERGE_TIMEOUT_EN
        check_val("to_fire", {63'd0, bus.wr_req}, 64'd1);
`else
        check_val("to_never", {63'd0, bus.wr_req}, 64'd0);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
`endif
        check_val("to_wrdata", bus.wr_data, 64'h00000002_00000001);
        bus.wr_ack = 1'b1;
        @(negedge clk);
        bus.wr_ack = 1'b0;
        check_val("to_done_busy", {63'd0, bus.busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
